// File: rtl/store_drain_port_if.sv
`default_nettype none
// ============================================================================
// Module   : store_drain_port_if
// Purpose  : Bundles the commit, load and memory-port signals of the drain
//            port. The slave modport is the drain port. The master modport is
//            the surrounding logic, meaning the store buffer, the load unit
//            and the data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface store_drain_port_if #(
  parameter int DEPTH = 4
) ();

  logic                   st_valid1;
  logic [31:0]            st_addr1;
  logic [31:0]            st_data1;
  logic                   st_valid2;
  logic [31:0]            st_addr2;
  logic [31:0]            st_data2;
  logic                   st_ready;

  logic                   ld_req;
  logic [31:0]            ld_addr;
  logic                   ld_stall;
  logic                   ld_valid;
  logic [31:0]            ld_data;

  logic                   mem_re;
  logic                   mem_we;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;

  logic                   empty;
  logic [$clog2(DEPTH):0] count;

  modport slave (
    input  st_valid1, st_addr1, st_data1, st_valid2, st_addr2, st_data2,
    output st_ready,
    input  ld_req, ld_addr,
    output ld_stall, ld_valid, ld_data,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output empty, count
  );

  modport master (
    output st_valid1, st_addr1, st_data1, st_valid2, st_addr2, st_data2,
    input  st_ready,
    output ld_req, ld_addr,
    input  ld_stall, ld_valid, ld_data,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  empty, count
  );

endinterface
`default_nettype wire

// File: rtl/store_drain_port.sv
`default_nettype none
// ============================================================================
// Module   : store_drain_port
// Purpose  : Memory-side end of the commit path.
//            - Accepts up to two committed stores per cycle into an in-order
//              drain FIFO.
//            - Drains one store per cycle into a single-port synchronous
//              memory.
//            - Arbitrates that port against load reads. Loads that alias a
//              pending store are stalled, and stores cannot starve for more
//              than STARVE_MAX cycles.
// Config   : `define DRAIN_FWD_EN serves aliasing loads from the youngest
//            matching FIFO entry instead of stalling them.
// Revision : 1.0 - initial release
// ============================================================================
module store_drain_port #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  store_drain_port_if.slave bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_stv_w = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [31:0]        r_addr [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic [c_stv_w-1:0] r_starve;
  logic               r_ld_valid;
  logic               r_sel_mem;
  logic [31:0]        r_ld_data;

  logic [DEPTH-1:0]   w_match;
  logic               w_hazard;
  logic               w_st_ready;
  logic               w_enq1;
  logic               w_enq2;
  logic [1:0]         w_enq_n;
  logic               w_store_win;
  logic               w_load_win;
  logic               w_fwd;
  logic [31:0]        w_fwd_data;

  // An entry is occupied when its distance from head is below count.
  // Only occupied entries may raise a hazard.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [c_ptr_w-1:0] w_off;
    assign w_off        = c_ptr_w'(gi) - r_head;
    assign w_match[gi]  = ({1'b0, w_off} < r_count) && (r_addr[gi] == bus.ld_addr);
  end

  assign w_hazard    = |w_match;
  assign w_st_ready  = (r_count <= c_cnt_w'(DEPTH - 2));
  assign w_enq1      = bus.st_valid1 && w_st_ready;
  assign w_enq2      = w_enq1 && bus.st_valid2;
  assign w_enq_n     = {1'b0, w_enq1} + {1'b0, w_enq2};

  // The store takes the port on any of these conditions:
  // - no load is requesting it;
  // - the store has lost to loads for STARVE_MAX cycles in a row;
  // - the FIFO is full;
  // - the load aliases a pending store, so the store must drain first.
  assign w_store_win = (r_count != '0) &&
                       (!bus.ld_req || (r_starve == c_stv_w'(STARVE_MAX)) ||
                        (r_count == c_cnt_w'(DEPTH)) || w_hazard);
  assign w_load_win  = rst && !w_store_win && bus.ld_req && !w_hazard;

`ifdef DRAIN_FWD_EN
  // Walk the FIFO from oldest to youngest so that the last hit, the youngest
  // matching store, supplies the forwarded data.
  always_comb begin
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[r_head + c_ptr_w'(k)]) begin
        w_fwd_data = r_data[r_head + c_ptr_w'(k)];
      end
    end
  end
  assign w_fwd = rst && bus.ld_req && w_hazard;
`else
  assign w_fwd_data = '0;
  assign w_fwd      = 1'b0;
`endif

  assign bus.st_ready  = w_st_ready;
  assign bus.empty     = (r_count == '0);
  assign bus.count     = r_count;
  assign bus.ld_stall  = rst && bus.ld_req && !(w_load_win || w_fwd);
  assign bus.ld_valid  = r_ld_valid;
  // Memory read data arrives one cycle after mem_re. It is presented
  // directly in that cycle and captured afterwards, so that ld_data holds
  // its value.
  assign bus.ld_data   = r_sel_mem ? bus.mem_rdata : r_ld_data;
  assign bus.mem_we    = w_store_win;
  assign bus.mem_re    = w_load_win;
  assign bus.mem_addr  = w_store_win ? r_addr[r_head] : (w_load_win ? bus.ld_addr : '0);
  assign bus.mem_wdata = w_store_win ? r_data[r_head] : '0;

  // FIFO storage. It holds only payload, so it needs no reset; occupancy
  // comes from count.
  always_ff @(posedge clk) begin
    if (w_enq1) begin
      r_addr[r_tail] <= bus.st_addr1;
      r_data[r_tail] <= bus.st_data1;
    end
    if (w_enq2) begin
      r_addr[r_tail + c_ptr_w'(1)] <= bus.st_addr2;
      r_data[r_tail + c_ptr_w'(1)] <= bus.st_data2;
    end
  end

  // Control state includes the pointers, the count, the starvation counter
  // and the load return path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_ld_valid <= 1'b0;
      r_sel_mem  <= 1'b0;
      r_ld_data  <= '0;
    end else begin
      if (w_enq2) begin
        r_tail <= r_tail + c_ptr_w'(2);
      end else if (w_enq1) begin
        r_tail <= r_tail + c_ptr_w'(1);
      end
      if (w_store_win) begin
        r_head <= r_head + c_ptr_w'(1);
      end
      r_count <= r_count + c_cnt_w'(w_enq_n) - c_cnt_w'(w_store_win);

      if (w_store_win) begin
        r_starve <= '0;
      end else if (w_load_win && (r_count != '0) &&
                   (r_starve != c_stv_w'(STARVE_MAX))) begin
        r_starve <= r_starve + c_stv_w'(1);
      end

      r_ld_valid <= w_load_win || w_fwd;
      r_sel_mem  <= w_load_win;
      if (w_fwd) begin
        r_ld_data <= w_fwd_data;
      end else if (r_sel_mem) begin
        r_ld_data <= bus.mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_drain_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_drain_port
// Purpose  : Self-checking bench for store_drain_port.
//            - A queue-based reference model predicts the port and load
//              behaviour on every cycle.
//            - The bench also contains a small synchronous memory that
//              serves the DUT's memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_drain_port;

  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  ent_t        q[$];
  int          starve = 0;
  logic        exp_ld_valid = 1'b0;
  logic [31:0] exp_ld_data  = '0;
  logic        last_stall   = 1'b0;
  logic [31:0] ref_mem [256];
  logic [31:0] tb_mem  [256];

  always #5 clk = ~clk;

  store_drain_port_if #(.DEPTH(DEPTH)) bus ();

  store_drain_port #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Entered at posedge+1: drive inputs, check outputs against the model,
  // advance the model, then let the bench memory respond to the port.
  task automatic cycle(input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic v2, input logic [31:0] a2, input logic [31:0] d2,
                       input logic lr, input logic [31:0] la);
    int          cnt;
    logic        hz, sw, lw, fw, rdy, nv;
    logic [31:0] fd, nd;
    logic        cap_we, cap_re;
    logic [31:0] cap_a, cap_d;
    bus.st_valid1 = v1; bus.st_addr1 = a1; bus.st_data1 = d1;
    bus.st_valid2 = v2; bus.st_addr2 = a2; bus.st_data2 = d2;
    bus.ld_req    = lr; bus.ld_addr  = la;
    #2;
    cnt = q.size();
    hz  = 1'b0;
    fd  = '0;
    foreach (q[i]) begin
      if (q[i].a == la) begin
        hz = 1'b1;
        fd = q[i].d;
      end
    end
    sw  = (cnt != 0) && (!lr || starve == SMAX || cnt == DEPTH || hz);
    lw  = !sw && lr && !hz;
    fw  = 1'b0;
`ifdef DRAIN_FWD_EN
    fw  = lr && hz;
`endif
    rdy = (cnt <= DEPTH - 2);

    check_val("st_ready", 32'(bus.st_ready), 32'(rdy));
    check_val("count",    32'(bus.count),    32'(cnt));
    check_val("empty",    32'(bus.empty),    32'(cnt == 0));
    check_val("ld_stall", 32'(bus.ld_stall), 32'(lr && !(lw || fw)));
    check_val("mem_we",   32'(bus.mem_we),   32'(sw));
    check_val("mem_re",   32'(bus.mem_re),   32'(lw));
    if (sw) begin
      check_val("st_addr",  bus.mem_addr,  q[0].a);
      check_val("st_wdata", bus.mem_wdata, q[0].d);
    end else if (lw) begin
      check_val("ld_addr",  bus.mem_addr,  la);
    end
    check_val("ld_valid", 32'(bus.ld_valid), 32'(exp_ld_valid));
    check_val("ld_data",  bus.ld_data,       exp_ld_data);

    cap_we = bus.mem_we; cap_re = bus.mem_re;
    cap_a  = bus.mem_addr; cap_d = bus.mem_wdata;

    nv = 1'b0;
    nd = exp_ld_data;
    if (lw) begin
      nv = 1'b1;
      nd = ref_mem[la[7:0]];
    end else if (fw) begin
      nv = 1'b1;
      nd = fd;
    end
    if (sw) begin
      ref_mem[q[0].a[7:0]] = q[0].d;
      void'(q.pop_front());
      starve = 0;
    end else if (lw && cnt != 0 && starve < SMAX) begin
      starve++;
    end
    if (v1 && rdy) begin
      q.push_back('{a: a1, d: d1});
      if (v2) q.push_back('{a: a2, d: d2});
    end
    exp_ld_valid = nv;
    exp_ld_data  = nd;
    last_stall   = lr && !(lw || fw);

    @(posedge clk);
    #1;
    if (cap_we) tb_mem[cap_a[7:0]] = cap_d;
    if (cap_re) bus.mem_rdata = tb_mem[cap_a[7:0]];
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic load_until_granted(input logic [31:0] la);
    int guard = 0;
    do begin
      cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, la);
      guard++;
    end while (last_stall && guard < 10);
    check_val("ld_grant_bound", 32'(last_stall), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.st_valid1 = 1'b0; bus.st_valid2 = 1'b0;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h10;
    #2;
    check_val("rst_mem_re",    32'(bus.mem_re),   32'(0));
    check_val("rst_mem_we",    32'(bus.mem_we),   32'(0));
    check_val("rst_ld_stall",  32'(bus.ld_stall), 32'(0));
    check_val("rst_st_ready",  32'(bus.st_ready), 32'(1));
    check_val("rst_empty",     32'(bus.empty),    32'(1));
    check_val("rst_count",     32'(bus.count),    32'(0));
    check_val("rst_ld_valid",  32'(bus.ld_valid), 32'(0));
    check_val("rst_ld_data",   bus.ld_data,       32'h0);
    check_val("rst_mem_addr",  bus.mem_addr,      32'h0);
    check_val("rst_mem_wdata", bus.mem_wdata,     32'h0);
    q.delete();
    starve       = 0;
    exp_ld_valid = 1'b0;
    exp_ld_data  = '0;
    last_stall   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  logic        r_lr;
  logic [31:0] r_la;
  int          ld_pct;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    bus.mem_rdata = '0;
    bus.st_addr1 = '0; bus.st_data1 = '0; bus.st_addr2 = '0; bus.st_data2 = '0;
    #1;
    do_reset();

    // Dual commit followed by two drain cycles.
    cycle(1'b1, 32'h10, 32'hAA, 1'b1, 32'h14, 32'hBB, 1'b0, '0);
    idle(); idle(); idle();

    // Fill past capacity while loads keep the port busy.
    do_reset();
    cycle(1'b1, 32'h20, 32'h1, 1'b1, 32'h21, 32'h2, 1'b1, 32'h3F);
    cycle(1'b1, 32'h22, 32'h3, 1'b1, 32'h23, 32'h4, 1'b1, 32'h3F);
    repeat (4) cycle(1'b1, 32'h24, 32'h5, 1'b1, 32'h25, 32'h6, 1'b1, 32'h3F);
    repeat (6) idle();

    // Starvation bound: three loads, then a forced store.
    do_reset();
    cycle(1'b1, 32'h20, 32'h77, 1'b0, '0, '0, 1'b0, '0);
    repeat (5) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 32'h40);
    idle(); idle();

    // Load aliasing a single pending store.
    do_reset();
    cycle(1'b1, 32'h30, 32'h55, 1'b0, '0, '0, 1'b0, '0);
    load_until_granted(32'h30);
    idle(); idle();

    // Two pending stores to the same address; the youngest value must win.
    do_reset();
    cycle(1'b1, 32'h50, 32'h1, 1'b1, 32'h50, 32'h2, 1'b0, '0);
    load_until_granted(32'h50);
    idle(); idle(); idle();

    // Randomized traffic over a small address pool to provoke hazards.
    do_reset();
    r_lr = 1'b0;
    r_la = 32'h10;
    for (int n = 0; n < 1500; n++) begin
      ld_pct = (n < 500) ? 50 : ((n < 1000) ? 90 : 30);
      if (!last_stall) begin
        r_lr = ($urandom_range(0, 99) < ld_pct);
        r_la = 32'h10 + 32'($urandom_range(0, 5));
      end
      cycle(($urandom_range(0, 99) < 35), 32'h10 + 32'($urandom_range(0, 5)), $urandom,
            1'($urandom_range(0, 1)),     32'h10 + 32'($urandom_range(0, 5)), $urandom,
            r_lr, r_la);
      if (n == 750) do_reset();
    end
    repeat (8) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
